// File: rtl/fp_result_checker.sv
// Expected-result scoreboard for fp_unit: a FIFO of expected entries popped and compared
// on every response, with canonical-NaN masking, a saturating pass counter and first-failure capture.
module fp_result_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [63:0]                  issue_result,
    input  logic [4:0]                   issue_flags,
    input  logic [1:0]                   issue_fmt,
    input  logic                         issue_f2i,
    input  logic                         rsp_ready,
    input  logic [63:0]                  rsp_result,
    input  logic [4:0]                   rsp_flags,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             pass_count,
    output logic [63:0]                  fail_exp_res,
    output logic [63:0]                  fail_calc_res,
    output logic [4:0]                   fail_exp_flg,
    output logic [4:0]                   fail_calc_flg,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FAIL = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  flg;
        logic [1:0]  fmt;
        logic        f2i;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [63:0]      exp_res_q, exp_res_d, calc_res_q, calc_res_d;
    logic [4:0]       exp_flg_q, exp_flg_d, calc_flg_q, calc_flg_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    entry_t      head;
    logic        run, empty_w, full_w, pop, push, err_ovf, err_unf, mismatch;
    logic        nan_s, nan_d;
    logic [63:0] diff;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        head    = mem_q[rd_ptr_q];
        run     = (state_q == ST_RUN);
        empty_w = (count_q == '0);
        full_w  = (count_q == DEPTH_C);
        pop     = run && rsp_ready && !empty_w;
        err_unf = run && rsp_ready && empty_w;
        err_ovf = run && issue_valid && full_w && !pop;
        // An underflow cycle performs no push even when issue_valid is high.
        push    = run && issue_valid && (!full_w || pop) && !err_unf;

        // A canonical NaN from fp_unit only has to agree on exponent and quiet bit.
        nan_s = (head.fmt == 2'd0) && !head.f2i && (rsp_result[31:0] == 32'h7FC0_0000);
        nan_d = (head.fmt != 2'd0) && !head.f2i && (rsp_result == 64'h7FF8_0000_0000_0000);
        diff  = rsp_result ^ head.res;
        if (nan_s)      diff = {55'd0, rsp_result[30:22] ^ head.res[30:22]};
        else if (nan_d) diff = {52'd0, rsp_result[62:51] ^ head.res[62:51]};
        mismatch = pop && ((diff != 64'd0) || (rsp_flags != head.flg));

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        pass_d     = pass_q;
        exp_res_d  = exp_res_q;
        calc_res_d = calc_res_q;
        exp_flg_d  = exp_flg_q;
        calc_flg_d = calc_flg_q;
        ovf_d      = ovf_q | err_ovf;
        unf_d      = unf_q | err_unf;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        if (pop && !mismatch && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
        if (mismatch) begin
            exp_res_d  = head.res;
            calc_res_d = rsp_result;
            exp_flg_d  = head.flg;
            calc_flg_d = rsp_flags;
        end

        if (err_ovf || err_unf) state_d = ST_ERR;
        else if (mismatch)      state_d = ST_FAIL;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_RUN;
            pass_q     <= '0;
            exp_res_q  <= '0;
            calc_res_q <= '0;
            exp_flg_q  <= '0;
            calc_flg_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            pass_q     <= pass_d;
            exp_res_q  <= exp_res_d;
            calc_res_q <= calc_res_d;
            exp_flg_q  <= exp_flg_d;
            calc_flg_q <= calc_flg_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // NOTE: the entry storage is not reset; pointers and count decide what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= '{res: issue_result, flg: issue_flags,
                                       fmt: issue_fmt, f2i: issue_f2i};
    end

    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign state         = state_q;
    assign pass_count    = pass_q;
    assign fail_exp_res  = exp_res_q;
    assign fail_calc_res = calc_res_q;
    assign fail_exp_flg  = exp_flg_q;
    assign fail_calc_flg = calc_flg_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: directed scenarios plus a randomized run, all checked
// against a queue-based reference model of the scoreboard.
module tb_fp_result_checker;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [63:0] issue_result = '0;
    logic [4:0]  issue_flags = '0;
    logic [1:0]  issue_fmt = '0;
    logic        issue_f2i = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result = '0;
    logic [4:0]  rsp_flags = '0;
    logic [3:0]  count;
    logic        full, empty;
    logic [1:0]  state;
    logic [31:0] pass_count;
    logic [63:0] fail_exp_res, fail_calc_res;
    logic [4:0]  fail_exp_flg, fail_calc_flg;
    logic        overflow, underflow;

    fp_result_checker #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_result(issue_result), .issue_flags(issue_flags),
        .issue_fmt(issue_fmt), .issue_f2i(issue_f2i),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .count(count), .full(full), .empty(empty), .state(state), .pass_count(pass_count),
        .fail_exp_res(fail_exp_res), .fail_calc_res(fail_calc_res),
        .fail_exp_flg(fail_exp_flg), .fail_calc_flg(fail_calc_flg),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;
        logic [1:0]  fmt;
        bit          f2i;
    } exp_t;

    exp_t        q[$];
    int          m_state;
    logic [31:0] m_pass;
    logic [63:0] m_cexp, m_ccalc;
    logic [4:0]  m_fexp, m_fcalc;
    bit          m_ovf, m_unf;
    int          errors = 0;
    int          checks = 0;

    function automatic bit ref_match(exp_t e, logic [63:0] c, logic [4:0] cf);
        bit res_ok;
        if (!e.f2i && e.fmt == 2'd0 && c[31:0] == 32'h7FC0_0000)
            res_ok = (c[30:22] == e.res[30:22]);
        else if (!e.f2i && e.fmt != 2'd0 && c == 64'h7FF8_0000_0000_0000)
            res_ok = (c[62:51] == e.res[62:51]);
        else
            res_ok = (c == e.res);
        return res_ok && (cf == e.flg);
    endfunction

    task automatic model_reset();
        q.delete();
        m_state = 0; m_pass = '0; m_cexp = '0; m_ccalc = '0;
        m_fexp = '0; m_fcalc = '0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit v, input exp_t ne, input bit rd,
                              input logic [63:0] cr, input logic [4:0] cf);
        bit do_pop, unf, ovf, mism;
        if (m_state != 0) return;
        do_pop = rd && q.size() > 0;
        unf    = rd && q.size() == 0;
        ovf    = v && q.size() == DEPTH && !do_pop;
        mism   = 0;
        if (do_pop) begin
            if (ref_match(q[0], cr, cf)) begin
                if (m_pass != 32'hFFFF_FFFF) m_pass++;
            end else begin
                mism = 1;
                m_cexp = q[0].res; m_ccalc = cr; m_fexp = q[0].flg; m_fcalc = cf;
            end
        end
        if (unf || ovf) begin
            m_unf |= unf; m_ovf |= ovf; m_state = 2;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (v) q.push_back(ne);
            if (mism) m_state = 1;
        end
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic drive(input bit v, input logic [63:0] er, input logic [4:0] ef,
                         input logic [1:0] fm, input bit f2, input bit rd,
                         input logic [63:0] cr, input logic [4:0] cf);
        exp_t ne;
        ne.res = er; ne.flg = ef; ne.fmt = fm; ne.f2i = f2;
        issue_valid = v; issue_result = er; issue_flags = ef; issue_fmt = fm; issue_f2i = f2;
        rsp_ready = rd; rsp_result = cr; rsp_flags = cf;
        model_step(v, ne, rd, cr, cf);
        @(posedge clock);
        #1;
        issue_valid = 0; rsp_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b want=10", empty, full); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (pass_count !== 32'd0) begin errors++; $display("FAIL reset_pass got=%0d want=0", pass_count); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky got=%b want=00", {overflow, underflow}); end
        checks++; if (fail_exp_res !== 64'd0 || fail_calc_res !== 64'd0) begin errors++; $display("FAIL reset_capture got=%h/%h want=0/0", fail_exp_res, fail_calc_res); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 64'h3F80_0000, 5'd0, 2'd0, 0, 0, 64'd0, 5'd0);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL basic_fill got=%0d want=4", count); end
        for (int i = 0; i < 4; i++) drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'h3F80_0000, 5'd0);
        checks++; if (pass_count !== 32'd4) begin errors++; $display("FAIL basic_pass got=%0d want=4", pass_count); end
        checks++; if (empty !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL basic_end got=empty%b st%0d want=empty1 st0", empty, state); end
    endtask

    task automatic test_nan_mask();
        do_reset();
        drive(1, 64'h7FC0_0001, 5'd0, 2'd0, 0, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'h7FC0_0000, 5'd0);
        checks++; if (pass_count !== 32'd1 || state !== 2'd0) begin errors++; $display("FAIL nan_single_mask got=p%0d st%0d want=p1 st0", pass_count, state); end
        // Single canonical NaN ignores the upper word of the response.
        drive(1, 64'h7FC0_0000, 5'd0, 2'd0, 0, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'hDEAD_BEEF_7FC0_0000, 5'd0);
        checks++; if (pass_count !== 32'd2 || state !== 2'd0) begin errors++; $display("FAIL nan_upper_word got=p%0d st%0d want=p2 st0", pass_count, state); end
        drive(1, 64'h7FF8_0000_0000_0001, 5'd0, 2'd1, 0, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'h7FF8_0000_0000_0000, 5'd0);
        checks++; if (pass_count !== 32'd3 || state !== 2'd0) begin errors++; $display("FAIL nan_double_mask got=p%0d st%0d want=p3 st0", pass_count, state); end
        drive(1, 64'h7FC0_0001, 5'd0, 2'd0, 1, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'h7FC0_0000, 5'd0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL nan_f2i_state got=%0d want=1", state); end
        checks++; if (fail_exp_res !== 64'h7FC0_0001 || fail_calc_res !== 64'h7FC0_0000) begin errors++; $display("FAIL nan_f2i_capture got=%h/%h want=7fc00001/7fc00000", fail_exp_res, fail_calc_res); end
        checks++; if (pass_count !== 32'd3) begin errors++; $display("FAIL nan_f2i_pass got=%0d want=3", pass_count); end
    endtask

    task automatic test_flags();
        do_reset();
        drive(1, 64'h4000_0000_0000_0000, 5'b00001, 2'd1, 0, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'h4000_0000_0000_0000, 5'b00000);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL flags_state got=%0d want=1", state); end
        checks++; if (fail_exp_flg !== 5'b00001 || fail_calc_flg !== 5'b00000) begin errors++; $display("FAIL flags_capture got=%b/%b want=00001/00000", fail_exp_flg, fail_calc_flg); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 64'(i + 100), 5'd0, 2'd1, 0, 0, 64'd0, 5'd0);
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_fill got=c%0d f%b want=c8 f1", count, full); end
        drive(1, 64'd200, 5'd0, 2'd1, 0, 1, 64'd100, 5'd0);
        checks++; if (count !== 4'd8 || overflow !== 1'b0 || pass_count !== 32'd1) begin errors++; $display("FAIL full_pushpop got=c%0d o%b p%0d want=c8 o0 p1", count, overflow, pass_count); end
        drive(1, 64'd201, 5'd0, 2'd1, 0, 0, 64'd0, 5'd0);
        checks++; if (overflow !== 1'b1 || state !== 2'd2 || count !== 4'd8) begin errors++; $display("FAIL full_overflow got=o%b st%0d c%0d want=o1 st2 c8", overflow, state, count); end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1, 64'd5, 5'd0, 2'd0, 0, 1, 64'd5, 5'd0);
        checks++; if (underflow !== 1'b1 || state !== 2'd2 || count !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL underflow got=u%b st%0d c%0d o%b want=u1 st2 c0 o0", underflow, state, count, overflow); end
    endtask

    task automatic test_reset_in_fail();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 64'(i + 16), 5'd0, 2'd1, 0, 0, 64'd0, 5'd0);
        drive(0, 64'd0, 5'd0, 2'd0, 0, 1, 64'd99, 5'd0);
        checks++; if (state !== 2'd1 || count !== 4'd3) begin errors++; $display("FAIL fail_entry got=st%0d c%0d want=st1 c3", state, count); end
        drive(1, 64'd7, 5'd0, 2'd1, 0, 1, 64'd17, 5'd0);
        checks++; if (count !== 4'd3 || pass_count !== 32'd0 || fail_calc_res !== 64'd99) begin errors++; $display("FAIL fail_frozen got=c%0d p%0d cap%0d want=c3 p0 cap99", count, pass_count, fail_calc_res); end
        do_reset();
        checks++; if (state !== 2'd0 || count !== 4'd0 || pass_count !== 32'd0) begin errors++; $display("FAIL rst_after_fail got=st%0d c%0d p%0d want=0/0/0", state, count, pass_count); end
        checks++; if (fail_exp_res !== 64'd0 || fail_calc_res !== 64'd0 || fail_exp_flg !== 5'd0 || fail_calc_flg !== 5'd0) begin errors++; $display("FAIL rst_capture got=%h/%h want=0/0", fail_exp_res, fail_calc_res); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit v, rd;
            logic [63:0] er, cr;
            logic [4:0] ef, cf;
            logic [1:0] fm;
            bit f2;
            if (m_state != 0 && $urandom_range(0, 3) == 0) do_reset();
            rd = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 149) == 0);
            v  = $urandom_range(0, 99) < 55;
            if (q.size() == DEPTH && !rd) v = ($urandom_range(0, 19) == 0);
            fm = 2'($urandom_range(0, 3));
            f2 = ($urandom_range(0, 4) == 0);
            ef = 5'($urandom);
            er = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) er[31:0] = 32'h7FC0_0000 | 32'($urandom_range(0, 3));
            cr = {$urandom, $urandom};
            cf = 5'($urandom);
            if (q.size() > 0) begin
                cr = q[0].res; cf = q[0].flg;
                case ($urandom_range(0, 29))
                    0: cr = cr ^ (64'd1 << $urandom_range(0, 63));
                    1: cf = cf ^ (5'd1 << $urandom_range(0, 4));
                    2: cr = {$urandom, 32'h7FC0_0000};
                    3: cr = 64'h7FF8_0000_0000_0000;
                    default: ;
                endcase
            end
            drive(v, er, ef, fm, f2, rd, cr, cf);
            checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, q.size()); end
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state n=%0d got=%0d want=%0d", n, state, m_state); end
            checks++; if (pass_count !== m_pass) begin errors++; $display("FAIL rnd_pass n=%0d got=%0d want=%0d", n, pass_count, m_pass); end
            checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_sticky n=%0d got=%b want=%b", n, {overflow, underflow}, {m_ovf, m_unf}); end
            checks++; if (fail_exp_res !== m_cexp || fail_calc_res !== m_ccalc) begin errors++; $display("FAIL rnd_cap_res n=%0d got=%h/%h want=%h/%h", n, fail_exp_res, fail_calc_res, m_cexp, m_ccalc); end
            checks++; if (fail_exp_flg !== m_fexp || fail_calc_flg !== m_fcalc) begin errors++; $display("FAIL rnd_cap_flg n=%0d got=%b/%b want=%b/%b", n, fail_exp_flg, fail_calc_flg, m_fexp, m_fcalc); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_empty_full n=%0d got=%b%b want=%b%b", n, empty, full, q.size() == 0, q.size() == DEPTH); end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_nan_mask();
        test_flags();
        test_full();
        test_underflow();
        test_reset_in_fail();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
